// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write controller.
// Holds the command bytes, the state encodings and the power-on init script.
package lcd_pkg;

    localparam logic [7:0] LCD_CLEAR   = 8'h01;
    localparam logic [7:0] LCD_DISP_ON = 8'h0C;
    localparam logic [7:0] LCD_ENTRY   = 8'h06;
    localparam logic [7:0] LCD_FS8     = 8'h38;
    localparam logic [7:0] LCD_FS4     = 8'h28;
    localparam logic [7:0] LCD_WAKE    = 8'h30;
    localparam logic [7:0] LCD_NIB4    = 8'h20;

    typedef enum logic [1:0] {
        ST_POWERUP,
        ST_XFER,
        ST_WAIT,
        ST_IDLE
    } ctrl_state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_PULSE,
        PH_HOLD
    } phy_state_t;

    typedef struct packed {
        logic       single;
        logic [7:0] code;
    } init_op_t;

    // single=1: only the upper nibble goes out in 4-bit mode
    function automatic init_op_t init_op(input logic four_bit, input logic [2:0] step);
        init_op_t op;
        op = '{single: 1'b1, code: LCD_WAKE};
        if (four_bit) begin
            case (step)
                3'd3:    op = '{single: 1'b1, code: LCD_NIB4};
                3'd4:    op = '{single: 1'b0, code: LCD_FS4};
                3'd5:    op = '{single: 1'b0, code: LCD_DISP_ON};
                3'd6:    op = '{single: 1'b0, code: LCD_CLEAR};
                3'd7:    op = '{single: 1'b0, code: LCD_ENTRY};
                default: ;
            endcase
        end else begin
            case (step)
                3'd3:    op = '{single: 1'b0, code: LCD_FS8};
                3'd4:    op = '{single: 1'b0, code: LCD_DISP_ON};
                3'd5:    op = '{single: 1'b0, code: LCD_CLEAR};
                3'd6:    op = '{single: 1'b0, code: LCD_ENTRY};
                default: ;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/lcd_write_phy.sv
// One HD44780 bus write: SETUP (E low), PULSE (E high), HOLD (E low).
// Data and RS are latched on start and stay put until the next start.
module lcd_write_phy
    import lcd_pkg::*;
#(
    parameter int BUS_WIDTH   = 8,
    parameter int T_SETUP_CYC = 2,
    parameter int T_EN_CYC    = 12
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_rs,
    input  logic [BUS_WIDTH-1:0] i_data,
    output logic                 o_done,
    output logic                 o_enable,
    output logic                 o_rs,
    output logic [BUS_WIDTH-1:0] o_lcd
);

    localparam logic [31:0] C_SETUP = 32'(T_SETUP_CYC - 1);
    localparam logic [31:0] C_EN    = 32'(T_EN_CYC - 1);

    phy_state_t           r_state;
    phy_state_t           w_state_n;
    logic [31:0]          r_cnt;
    logic [31:0]          w_cnt_n;
    logic                 r_rs;
    logic [BUS_WIDTH-1:0] r_lcd;

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        o_done    = 1'b0;
        unique case (r_state)
            PH_SETUP: begin
                if (r_cnt == 32'd0) begin
                    w_state_n = PH_PULSE;
                    w_cnt_n   = C_EN;
                end else begin
                    w_cnt_n = r_cnt - 32'd1;
                end
            end
            PH_PULSE: begin
                if (r_cnt == 32'd0) begin
                    w_state_n = PH_HOLD;
                    w_cnt_n   = C_SETUP;
                end else begin
                    w_cnt_n = r_cnt - 32'd1;
                end
            end
            PH_HOLD: begin
                if (r_cnt == 32'd0) begin
                    o_done    = 1'b1;
                    w_state_n = PH_IDLE;
                end else begin
                    w_cnt_n = r_cnt - 32'd1;
                end
            end
            default: ;
        endcase
        // back-to-back start from the last HOLD cycle skips IDLE
        if (i_start) begin
            w_state_n = PH_SETUP;
            w_cnt_n   = C_SETUP;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= PH_IDLE;
            r_cnt   <= 32'd0;
            r_rs    <= 1'b0;
            r_lcd   <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            if (i_start) begin
                r_rs  <= i_rs;
                r_lcd <= i_data;
            end
        end
    end

    assign o_enable = (r_state == PH_PULSE);
    assign o_rs     = r_rs;
    assign o_lcd    = r_lcd;

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 write controller: power-on init, 4/8-bit nibble split, post-write waits.
// Host bytes enter through a valid/ready port; the busy flag is never read.
module lcd_hd44780_ctrl
    import lcd_pkg::*;
#(
    parameter int BUS_WIDTH     = 8,
    parameter int T_POWERUP_CYC = 750000,
    parameter int T_INIT_CYC    = 205000,
    parameter int T_SETUP_CYC   = 2,
    parameter int T_EN_CYC      = 12,
    parameter int T_CMD_CYC     = 2000,
    parameter int T_CLEAR_CYC   = 82000
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 iValid,
    input  logic                 iRS,
    input  logic [7:0]           iData,
    output logic                 oReady,
    output logic                 oInitDone,
    output logic [BUS_WIDTH-1:0] oLCD,
    output logic                 oRegisterSelect,
    output logic                 oReadWrite,
    output logic                 oEnable
);

    if (BUS_WIDTH != 4 && BUS_WIDTH != 8) begin : g_bad_width
        $error("lcd_hd44780_ctrl: BUS_WIDTH must be 4 or 8");
    end
    if (T_POWERUP_CYC < 1 || T_INIT_CYC < 1 || T_SETUP_CYC < 1 ||
        T_EN_CYC < 1 || T_CMD_CYC < 1 || T_CLEAR_CYC < 1) begin : g_bad_time
        $error("lcd_hd44780_ctrl: timing parameters must be >= 1");
    end

    localparam logic        FOUR      = (BUS_WIDTH == 4);
    localparam logic [2:0]  LAST_STEP = FOUR ? 3'd7 : 3'd6;
    localparam logic [31:0] C_POWERUP = 32'(T_POWERUP_CYC - 1);
    localparam logic [31:0] C_INIT    = 32'(T_INIT_CYC - 1);
    localparam logic [31:0] C_CMD     = 32'(T_CMD_CYC - 1);
    localparam logic [31:0] C_CLEAR   = 32'(T_CLEAR_CYC - 1);

    ctrl_state_t          r_state;
    ctrl_state_t          w_state_n;
    logic [31:0]          r_cnt;
    logic [31:0]          w_cnt_n;
    logic [31:0]          w_wait_cnt;
    logic [2:0]           r_step;
    logic [2:0]           w_step_n;
    logic [2:0]           w_step_sel;
    logic [7:0]           r_byte;
    logic [7:0]           w_byte_n;
    logic                 r_rs;
    logic                 w_rs_n;
    logic                 r_second;
    logic                 w_second_n;
    logic                 r_init_done;
    logic                 w_init_done_n;
    init_op_t             w_init_op;
    logic                 w_launch;
    logic                 w_l_rs;
    logic                 w_l_single;
    logic [7:0]           w_l_byte;
    logic                 w_start;
    logic                 w_phy_rs;
    logic [BUS_WIDTH-1:0] w_phy_data;
    logic                 w_phy_done;

    assign w_step_sel = (r_state == ST_POWERUP) ? 3'd0 : 3'(r_step + 3'd1);
    assign w_init_op  = init_op(FOUR, w_step_sel);

    always_comb begin
        w_wait_cnt = C_CMD;
        if (!r_init_done && r_step == 3'd0) begin
            w_wait_cnt = C_INIT;
        end else if (!r_rs && r_byte >= 8'h01 && r_byte <= 8'h03) begin
            w_wait_cnt = C_CLEAR;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_step_n      = r_step;
        w_byte_n      = r_byte;
        w_rs_n        = r_rs;
        w_second_n    = r_second;
        w_init_done_n = r_init_done;
        w_start       = 1'b0;
        w_phy_rs      = r_rs;
        w_phy_data    = r_byte[BUS_WIDTH-1:0];
        w_launch      = 1'b0;
        w_l_rs        = 1'b0;
        w_l_byte      = w_init_op.code;
        w_l_single    = w_init_op.single;
        unique case (r_state)
            ST_POWERUP: begin
                if (r_cnt == 32'd0) begin
                    w_launch = 1'b1;
                    w_step_n = 3'd0;
                end else begin
                    w_cnt_n = r_cnt - 32'd1;
                end
            end
            ST_XFER: begin
                if (w_phy_done) begin
                    if (r_second) begin
                        w_start    = 1'b1;
                        w_second_n = 1'b0;
                    end else begin
                        w_state_n = ST_WAIT;
                        w_cnt_n   = w_wait_cnt;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt != 32'd0) begin
                    w_cnt_n = r_cnt - 32'd1;
                end else if (r_init_done) begin
                    w_state_n = ST_IDLE;
                end else if (r_step == LAST_STEP) begin
                    w_state_n     = ST_IDLE;
                    w_init_done_n = 1'b1;
                end else begin
                    w_launch = 1'b1;
                    w_step_n = w_step_sel;
                end
            end
            ST_IDLE: begin
                if (iValid) begin
                    w_launch   = 1'b1;
                    w_l_rs     = iRS;
                    w_l_byte   = iData;
                    w_l_single = 1'b0;
                end
            end
            default: ;
        endcase
        // upper nibble (or whole byte) goes out first
        if (w_launch) begin
            w_start    = 1'b1;
            w_state_n  = ST_XFER;
            w_byte_n   = w_l_byte;
            w_rs_n     = w_l_rs;
            w_second_n = FOUR && !w_l_single;
            w_phy_rs   = w_l_rs;
            w_phy_data = w_l_byte[7 -: BUS_WIDTH];
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state     <= ST_POWERUP;
            r_cnt       <= C_POWERUP;
            r_step      <= 3'd0;
            r_byte      <= 8'h00;
            r_rs        <= 1'b0;
            r_second    <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_step      <= w_step_n;
            r_byte      <= w_byte_n;
            r_rs        <= w_rs_n;
            r_second    <= w_second_n;
            r_init_done <= w_init_done_n;
        end
    end

    lcd_write_phy #(
        .BUS_WIDTH   (BUS_WIDTH),
        .T_SETUP_CYC (T_SETUP_CYC),
        .T_EN_CYC    (T_EN_CYC)
    ) u_phy (
        .i_clk    (Clock),
        .i_rst_n  (Reset),
        .i_start  (w_start),
        .i_rs     (w_phy_rs),
        .i_data   (w_phy_data),
        .o_done   (w_phy_done),
        .o_enable (oEnable),
        .o_rs     (oRegisterSelect),
        .o_lcd    (oLCD)
    );

    assign oReady     = (r_state == ST_IDLE);
    assign oInitDone  = r_init_done;
    assign oReadWrite = 1'b0;

endmodule
